morse_receiver: RTL and testbench
=================================

// Module: morse_receiver
// PURPOSE
//   Downstream consumer of the Morse transmitter's serial output (display strobe + dot/dash bit).
//   Samples the symbol stream on the half-second tick and collects up to MAX_LEN symbols.
//   Detects the inter-letter gap and decodes the symbols back to the 3-bit letter code A..H (0..7).
//   Used for loopback self-check of the transmitter on the board (letter_o -> LEDR / 7-seg).
// PARAMETERS
//   MAX_LEN    4  max symbols per letter; more before a gap = overflow
//   GAP_TICKS  3  consecutive idle ticks (dis_i=0) that close a letter
//   DASH_TICKS 2  mark length in ticks classed as dash (MORSE_RX_DURATION_EN only)
// PORTS
//   CLOCK_50  in   1  system clock, all state on rising edge
//   rst       in   1  asynchronous active-low reset
//   tick_i    in   1  one-cycle half-second enable; all sampling qualified by it
//   dis_i     in   1  symbol display active (mark) from transmitter
//   data_i    in   1  symbol type while dis_i=1: 0 dot, 1 dash
//   letter_o  out  3  last decoded letter (A=0..H=7), held until next valid_o
//   valid_o   out  1  one-cycle pulse: letter_o updated this cycle
//   err_o     out  1  one-cycle pulse: letter closed with no table match or overflow
//   busy_o    out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, rst=0): state=IDLE, sym_q=0, cnt=0, gap=0, ovf=0, letter_o=0, valid_o=0, err_o=0, busy_o=0.
//   Reset mid-letter discards the partial letter; no valid_o/err_o after release.
//   Nothing advances on cycles with tick_i=0; dis_i/data_i are ignored there.
//   Symbol store: sym_q <= {sym_q[2:0], sym}; cnt counts stored symbols, saturates at MAX_LEN.
//   First symbol ends up in bit cnt-1.
//   FSM (IDLE, MARK, SPACE, DONE):
//   - IDLE: tick & dis_i=1 -> store symbol, cnt=1, go to MARK.
//   - MARK: tick & dis_i=1 -> stay (same symbol, no new store).
//     tick & dis_i=0 -> go to SPACE with gap=1; if GAP_TICKS==1, go straight to DONE.
//   - SPACE: tick & dis_i=1 -> new symbol.
//       If cnt==MAX_LEN: set ovf, do not store, go to MARK.
//       Else: store, cnt+1, go to MARK.
//     tick & dis_i=0 -> gap+1; when gap reaches GAP_TICKS, go to DONE.
//   - DONE: exactly one cycle, no tick needed.
//       Look up (cnt, sym_q[cnt-1:0]) and go to IDLE; clear sym_q, cnt, gap, ovf.
//       Match & !ovf: letter_o <= code, valid_o=1.
//       Otherwise: err_o=1, letter_o unchanged.
//     A tick arriving in the DONE cycle is dropped.
//   Table (len:bits, first symbol at MSB):
//     A 2:01, B 4:1000, C 4:1010, D 3:100, E 1:0, F 4:0010, G 3:110, H 4:0000.
//   Latency: valid_o asserts 1 cycle after the tick that completes the GAP_TICKS-th idle tick.
//   valid_o and err_o are mutually exclusive registered pulses.
// CONFIGURATION
//   MORSE_RX_DURATION_EN defined:
//     data_i is ignored. Mark length is counted in ticks (saturating).
//     The symbol is a dash if length >= DASH_TICKS, else a dot.
//     It is stored at the MARK->SPACE/DONE transition, not at mark start.
//     The cnt/ovf check is unchanged.
//   Undefined (default):
//     Symbol = data_i sampled at the first tick of the mark; duration is irrelevant.
// TESTING
//   Reset: rst=0 mid-MARK of "-..." -> all outputs 0, IDLE; after release, 3 idle ticks give no pulse.
//   Stream A: ticks dis/data = 1/0, 0, 1/1, 0,0,0 -> valid_o pulse, letter_o=0.
//   Stream H (.... with 1-tick gaps, then 3 idle ticks) -> letter_o=7.
//     Then G (--.) -> letter_o=6; no err_o.
//   Overflow: 5 dots before gap -> err_o pulse, valid_o=0, letter_o keeps previous value.
//   No-match: "--" (len2:11) then gap -> err_o pulse. Mark held 3 ticks counts as one symbol.
//   MORSE_RX_DURATION_EN, DASH_TICKS=2: marks of 2,1,1,1 ticks, data_i=0 throughout -> B (1).
//   tick_i gaps: ticks spaced by 1..7 idle cycles give the same decode.

Source files
------------

// File: rtl/morse_receiver_if.sv
// morse_receiver_if
//   Groups the receiver's symbol-stream inputs and decoded-letter outputs.
//   master : the stream source (transmitter or testbench) drives tick/dis/data
//            and observes the decode results.
//   slave  : the receiver consumes the stream and drives the results.
//   Signals:
//     tick_i   half-second enable, one cycle wide
//     dis_i    mark present (symbol being displayed)
//     data_i   symbol type while dis_i=1: 0 dot, 1 dash
//     letter_o last decoded letter code (A=0..H=7)
//     valid_o  one-cycle pulse, letter_o updated
//     err_o    one-cycle pulse, letter rejected (no match or overflow)
//     busy_o   receiver not idle
interface morse_receiver_if;
  logic       tick_i;
  logic       dis_i;
  logic       data_i;
  logic [2:0] letter_o;
  logic       valid_o;
  logic       err_o;
  logic       busy_o;

  modport master (
    output tick_i, dis_i, data_i,
    input  letter_o, valid_o, err_o, busy_o
  );

  modport slave (
    input  tick_i, dis_i, data_i,
    output letter_o, valid_o, err_o, busy_o
  );
endinterface

// File: rtl/morse_receiver.sv
// morse_receiver
//   Loopback receiver for the Morse transmitter. Samples the dot/dash stream
//   on the half-second tick, collects up to MAX_LEN symbols, closes a letter
//   after GAP_TICKS idle ticks and decodes it to the letter code A..H (0..7).
//   Optional build macro MORSE_RX_DURATION_EN: data_i is ignored and each
//   symbol is classed by mark length (>= DASH_TICKS ticks is a dash), stored
//   when the mark ends. Without it the symbol is data_i at the mark's first tick.
//   Ports:
//     CLOCK_50  system clock, rising edge
//     rst       asynchronous active-low reset
//     bus       morse_receiver_if.slave (tick/dis/data in, letter/valid/err/busy out)
module morse_receiver #(
  parameter int MAX_LEN    = 4,
  parameter int GAP_TICKS  = 3,
  parameter int DASH_TICKS = 2
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  morse_receiver_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS);

  generate
    if (MAX_LEN < 1 || GAP_TICKS < 1 || DASH_TICKS < 1) begin : g_bad_param
      $error("morse_receiver: MAX_LEN, GAP_TICKS and DASH_TICKS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DONE} state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } lookup_t;

  // Symbols are shifted in at the LSB, so the first symbol of a letter of
  // length n sits at bit n-1; unused upper bits stay zero.
  function automatic lookup_t lookup(input logic [CNT_W-1:0] len, input logic [3:0] bits);
    lookup_t r;
    r = '{hit: 1'b1, code: 3'd0};
    case ({4'(len), bits})
      {4'd2, 4'b0001}: r.code = 3'd0;  // A .-
      {4'd4, 4'b1000}: r.code = 3'd1;  // B -...
      {4'd4, 4'b1010}: r.code = 3'd2;  // C -.-.
      {4'd3, 4'b0100}: r.code = 3'd3;  // D -..
      {4'd1, 4'b0000}: r.code = 3'd4;  // E .
      {4'd4, 4'b0010}: r.code = 3'd5;  // F ..-.
      {4'd3, 4'b0110}: r.code = 3'd6;  // G --.
      {4'd4, 4'b0000}: r.code = 3'd7;  // H ....
      default:         r.hit  = 1'b0;
    endcase
    return r;
  endfunction

  state_t               state_q;
  logic [MAX_LEN-1:0]   sym_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 ovf_q;
  logic [2:0]           letter_q;
  logic                 valid_q;
  logic                 err_q;

  logic                 sym_bit;
  logic [MAX_LEN-1:0]   sym_shift;
  lookup_t              lut;

`ifdef MORSE_RX_DURATION_EN
  localparam int LEN_W = $clog2(DASH_TICKS + 1);
  localparam logic [LEN_W-1:0] LEN_DASH = LEN_W'(DASH_TICKS);
  // Mark length only needs to reach DASH_TICKS, so it saturates there.
  logic [LEN_W-1:0] mlen_q;
  assign sym_bit = (mlen_q >= LEN_DASH);
`else
  assign sym_bit = bus.data_i;
`endif

  assign sym_shift = MAX_LEN'({sym_q, sym_bit});
  assign lut       = lookup(cnt_q, 4'(sym_q));

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of the registers, whatever the statement order.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sym_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      ovf_q    <= 1'b0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef MORSE_RX_DURATION_EN
      mlen_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.tick_i && bus.dis_i) begin
`ifdef MORSE_RX_DURATION_EN
            mlen_q  <= LEN_W'(1);
`else
            sym_q   <= sym_shift;
            cnt_q   <= CNT_W'(1);
`endif
            state_q <= MARK;
          end
        end

        MARK: begin
          if (bus.tick_i && !bus.dis_i) begin
`ifdef MORSE_RX_DURATION_EN
            // Mark just ended: its length decides the symbol.
            if (cnt_q == CNT_FULL) begin
              ovf_q <= 1'b1;
            end else begin
              sym_q <= sym_shift;
              cnt_q <= cnt_q + CNT_W'(1);
            end
`endif
            gap_q   <= GAP_W'(1);
            state_q <= (GAP_TICKS == 1) ? DONE : SPACE;
          end
`ifdef MORSE_RX_DURATION_EN
          else if (bus.tick_i && mlen_q != LEN_DASH) begin
            mlen_q <= mlen_q + LEN_W'(1);
          end
`endif
        end

        SPACE: begin
          if (bus.tick_i) begin
            if (bus.dis_i) begin
`ifdef MORSE_RX_DURATION_EN
              mlen_q <= LEN_W'(1);
`else
              if (cnt_q == CNT_FULL) begin
                ovf_q <= 1'b1;
              end else begin
                sym_q <= sym_shift;
                cnt_q <= cnt_q + CNT_W'(1);
              end
`endif
              state_q <= MARK;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
              if (gap_q + GAP_W'(1) == GAP_LAST) state_q <= DONE;
            end
          end
        end

        DONE: begin
          // Single cycle regardless of tick_i; a tick landing here is dropped.
          if (lut.hit && !ovf_q) begin
            letter_q <= lut.code;
            valid_q  <= 1'b1;
          end else begin
            err_q    <= 1'b1;
          end
          sym_q   <= '0;
          cnt_q   <= '0;
          gap_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.letter_o = letter_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver
//   Drives letters as tick-qualified mark/space streams from a table, predicts
//   each letter's outcome into a scoreboard queue, and a monitor pops and
//   compares whenever the receiver pulses valid_o or err_o. Hand-written
//   sequences cover reset mid-letter and a tick arriving in the DONE cycle.
module tb_morse_receiver;

`ifdef MORSE_RX_DURATION_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif
  localparam int GAP = 3;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  morse_receiver_if bus();

  morse_receiver #(
    .MAX_LEN   (4),
    .GAP_TICKS (GAP),
    .DASH_TICKS(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    int         len;
    logic [7:0] bits;     // first symbol at bit len-1, 1 = dash
    int         hold;     // ticks per mark when classed by data_i
    bit         jit;      // random 1..7 idle cycles between ticks
    bit         exp_err;
    logic [2:0] code;
  } vec_t;

  typedef struct {
    logic       v;
    logic       e;
    logic [2:0] letter;
    int         tick_cyc;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  exp_t       got;
  int         vectors    = 0;
  int         miscompares = 0;
  int         cyc        = 0;
  int         pulse_cnt  = 0;
  logic [2:0] model_letter = 3'd0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest prediction, two edges after
  // the closing tick (one edge into DONE, one edge out of it).
  always @(negedge CLOCK_50) begin
    if (rst && (bus.valid_o || bus.err_o)) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.valid_o, bus.err_o}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("valid",   {31'd0, bus.valid_o}, {31'd0, got.v});
        check("err",     {31'd0, bus.err_o},   {31'd0, got.e});
        check("letter",  {29'd0, bus.letter_o}, {29'd0, got.letter});
        check("latency", cyc - got.tick_cyc, 32'd2);
      end
    end
  end

  function automatic int sp(input bit jit);
    return jit ? int'($urandom_range(1, 7)) : 0;
  endfunction

  // Idle (tick_i=0) cycles carry random dis/data, which must be ignored.
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      bus.tick_i = 1'b0;
      bus.dis_i  = 1'($urandom);
      bus.data_i = 1'($urandom);
    end
  endtask

  task automatic do_tick(input logic d, input logic b, input int space);
    idle_cycles(space);
    @(negedge CLOCK_50);
    bus.tick_i = 1'b1;
    bus.dis_i  = d;
    bus.data_i = b;
  endtask

  task automatic push_exp(input bit err, input logic [2:0] code);
    exp_t e;
    e.v        = !err;
    e.e        = err;
    e.letter   = err ? model_letter : code;
    e.tick_cyc = cyc;
    if (!err) model_letter = code;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int w = 0;
    idle_cycles(1);
    while (sb.size() != 0 && w < 20) begin
      idle_cycles(1);
      w++;
    end
    idle_cycles(1);
    check({name, "_pulse_seen"}, sb.size(), 32'd0);
    check({name, "_idle_after"}, {31'd0, bus.busy_o}, 32'd0);
    sb.delete();
  endtask

  task automatic send_letter(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      logic b;
      int   marks;
      b     = v.bits[v.len-1-i];
      marks = DUR ? (b ? 2 : 1) : v.hold;
      for (int m = 0; m < marks; m++) do_tick(1'b1, DUR ? 1'b0 : b, sp(v.jit));
      if (i < v.len - 1) do_tick(1'b0, 1'($urandom), sp(v.jit));
    end
    for (int g = 0; g < GAP; g++) do_tick(1'b0, 1'($urandom), sp(v.jit));
    push_exp(v.exp_err, v.code);
    drain(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int snap;

    vecs.push_back('{"A",     2, 8'b01,    1, 1'b0, 1'b0, 3'd0});
    vecs.push_back('{"B",     4, 8'b1000,  1, 1'b1, 1'b0, 3'd1});
    vecs.push_back('{"C",     4, 8'b1010,  2, 1'b0, 1'b0, 3'd2});
    vecs.push_back('{"D",     3, 8'b100,   1, 1'b1, 1'b0, 3'd3});
    vecs.push_back('{"E",     1, 8'b0,     1, 1'b0, 1'b0, 3'd4});
    vecs.push_back('{"F",     4, 8'b0010,  1, 1'b1, 1'b0, 3'd5});
    vecs.push_back('{"H",     4, 8'b0000,  1, 1'b0, 1'b0, 3'd7});
    vecs.push_back('{"G",     3, 8'b110,   1, 1'b1, 1'b0, 3'd6});
    vecs.push_back('{"ovf",   5, 8'b00000, 1, 1'b0, 1'b1, 3'd0});
    vecs.push_back('{"nm_dd", 2, 8'b11,    3, 1'b0, 1'b1, 3'd0});
    vecs.push_back('{"nm_ddd",3, 8'b111,   1, 1'b1, 1'b1, 3'd0});

    bus.tick_i = 1'b0;
    bus.dis_i  = 1'b0;
    bus.data_i = 1'b0;

    // Reset state.
    repeat (2) @(negedge CLOCK_50);
    check("rst_letter", {29'd0, bus.letter_o}, 32'd0);
    check("rst_valid",  {31'd0, bus.valid_o},  32'd0);
    check("rst_err",    {31'd0, bus.err_o},    32'd0);
    check("rst_busy",   {31'd0, bus.busy_o},   32'd0);
    rst = 1'b1;
    idle_cycles(2);

    foreach (vecs[i]) send_letter(vecs[i]);

    // Reset in the middle of "-...": partial letter is discarded.
    if (DUR) begin
      do_tick(1'b1, 1'b0, 0);
      do_tick(1'b1, 1'b0, 0);
    end else begin
      do_tick(1'b1, 1'b1, 0);
    end
    do_tick(1'b0, 1'b0, 0);
    do_tick(1'b1, 1'b0, 0);
    @(posedge CLOCK_50);
    #2;
    check("busy_mid_letter", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_letter", {29'd0, bus.letter_o}, 32'd0);
    check("midrst_valid",  {31'd0, bus.valid_o},  32'd0);
    check("midrst_err",    {31'd0, bus.err_o},    32'd0);
    check("midrst_busy",   {31'd0, bus.busy_o},   32'd0);
    model_letter = 3'd0;
    idle_cycles(3);
    rst  = 1'b1;
    snap = pulse_cnt;
    for (int g = 0; g < GAP; g++) do_tick(1'b0, 1'b0, 0);
    idle_cycles(10);
    check("no_pulse_after_reset", pulse_cnt - snap, 32'd0);
    check("idle_after_reset", {31'd0, bus.busy_o}, 32'd0);

    // E with back-to-back ticks; a mark tick lands in the DONE cycle and
    // must be dropped, leaving the receiver idle.
    do_tick(1'b1, 1'b0, 0);
    for (int g = 0; g < GAP; g++) do_tick(1'b0, 1'b0, 0);
    push_exp(1'b0, 3'd4);
    do_tick(1'b1, 1'b1, 0);
    do_tick(1'b0, 1'b0, 0);
    drain("E_tick_in_done");

    idle_cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
